// File: rtl/alu_operand_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ADC/SBC operand sequencer.
//   - alu_seq_state_t : sequencer state encoding
//   - BYTE_W / WORD_W : memory byte width and accumulator word width
//   - is_zero()       : width-aware zero test used for the Z flag
package alu_seq_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_FETCH_HI = 3'd2,
        ST_EXEC     = 3'd3,
        ST_DONE     = 3'd4
    } alu_seq_state_t;

    // Zero test over the full word in 16-bit mode, low byte only in 8-bit mode.
    function automatic logic is_zero(input logic [WORD_W-1:0] v, input logic w16);
        logic z;
        if (w16) begin
            z = (v == 16'h0000);
        end else begin
            z = (v[BYTE_W-1:0] == 8'h00);
        end
        return z;
    endfunction

endpackage

// File: rtl/alu_operand_seq_if.sv
// alu_operand_seq_if: bundle of the sequencer's upstream control, byte-wide
// memory read port, adder operand/result port and result/flag outputs.
//   master : upstream sequencer + memory + adder side
//   slave  : the operand sequencer itself
interface alu_operand_seq_if;
    import alu_seq_pkg::*;

    // Upstream control
    logic              START;
    logic              CANCEL;
    logic              ADD;
    logic              BCD;
    logic              W16;
    logic              CI;
    logic [WORD_W-1:0] ACC;
    // Memory byte port
    logic              MEM_REQ;
    logic              MEM_HI;
    logic              MEM_ACK;
    logic [BYTE_W-1:0] MEM_DI;
    // Adder port
    logic [WORD_W-1:0] ADDER_A;
    logic [WORD_W-1:0] ADDER_B;
    logic              ADDER_CI;
    logic              ADDER_ADD;
    logic              ADDER_BCD;
    logic              ADDER_W16;
    logic [WORD_W-1:0] ADDER_S;
    logic              ADDER_CO;
    logic              ADDER_VO;
    // Results
    logic [WORD_W-1:0] RESULT;
    logic              C_OUT;
    logic              V_OUT;
    logic              N_OUT;
    logic              Z_OUT;
    logic              BUSY;
    logic              DONE;

    modport master (
        output START, CANCEL, ADD, BCD, W16, CI, ACC,
        output MEM_ACK, MEM_DI,
        output ADDER_S, ADDER_CO, ADDER_VO,
        input  MEM_REQ, MEM_HI,
        input  ADDER_A, ADDER_B, ADDER_CI, ADDER_ADD, ADDER_BCD, ADDER_W16,
        input  RESULT, C_OUT, V_OUT, N_OUT, Z_OUT, BUSY, DONE
    );

    modport slave (
        input  START, CANCEL, ADD, BCD, W16, CI, ACC,
        input  MEM_ACK, MEM_DI,
        input  ADDER_S, ADDER_CO, ADDER_VO,
        output MEM_REQ, MEM_HI,
        output ADDER_A, ADDER_B, ADDER_CI, ADDER_ADD, ADDER_BCD, ADDER_W16,
        output RESULT, C_OUT, V_OUT, N_OUT, Z_OUT, BUSY, DONE
    );

endinterface

// File: rtl/alu_operand_seq.sv
// alu_operand_seq: multi-cycle operand sequencer for the ADC/SBC datapath.
// Latches accumulator and mode bits on START, fetches an 8- or 16-bit memory
// operand one byte at a time, presents registered operands to the external
// AddSubBCD adder for one full EXEC cycle, then captures sum and flags.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : alu_operand_seq_if.slave (control, memory, adder, result signals)
module alu_operand_seq
    import alu_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    alu_operand_seq_if.slave bus
);

    alu_seq_state_t    state_q;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic              ci_q;
    logic              add_q;
    logic              bcd_q;
    logic              w16_q;
    logic [WORD_W-1:0] result_q;
    logic              c_q;
    logic              v_q;
    logic              n_q;
    logic              z_q;

    logic [WORD_W-1:0] result_d;
    logic              n_d;
    logic              z_d;

    // Result and N/Z selection for the EXEC capture; byte mode keeps the B accumulator.
    always_comb begin
        result_d = bus.ADDER_S;
        n_d      = 1'b0;
        z_d      = is_zero(bus.ADDER_S, w16_q);
        if (w16_q) begin
            result_d = bus.ADDER_S;
            n_d      = bus.ADDER_S[WORD_W-1];
        end else begin
            result_d = {a_q[WORD_W-1:BYTE_W], bus.ADDER_S[BYTE_W-1:0]};
            n_d      = bus.ADDER_S[BYTE_W-1];
        end
    end

    // Sequencer FSM with latched operands/controls and the captured result register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            ci_q     <= 1'b0;
            add_q    <= 1'b0;
            bcd_q    <= 1'b0;
            w16_q    <= 1'b0;
            result_q <= 16'h0000;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else if (bus.CANCEL) begin
            // Abort wins over START and MEM_ACK; result and flags are left untouched.
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.START) begin
                        a_q     <= bus.ACC;
                        ci_q    <= bus.CI;
                        add_q   <= bus.ADD;
                        bcd_q   <= bus.BCD;
                        w16_q   <= bus.W16;
                        b_q     <= 16'h0000;
                        state_q <= ST_FETCH_LO;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FETCH_LO: begin
                    if (bus.MEM_ACK) begin
                        b_q[BYTE_W-1:0] <= bus.MEM_DI;
                        state_q         <= w16_q ? ST_FETCH_HI : ST_EXEC;
                    end else begin
                        state_q <= ST_FETCH_LO;
                    end
                end
                ST_FETCH_HI: begin
                    if (bus.MEM_ACK) begin
                        b_q[WORD_W-1:BYTE_W] <= bus.MEM_DI;
                        state_q              <= ST_EXEC;
                    end else begin
                        state_q <= ST_FETCH_HI;
                    end
                end
                ST_EXEC: begin
                    result_q <= result_d;
                    c_q      <= bus.ADDER_CO;
                    v_q      <= bus.ADDER_VO;
                    n_q      <= n_d;
                    z_q      <= z_d;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded directly from the state register.
    assign bus.MEM_REQ   = (state_q == ST_FETCH_LO) || (state_q == ST_FETCH_HI);
    assign bus.MEM_HI    = (state_q == ST_FETCH_HI);
    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.DONE      = (state_q == ST_DONE);

    assign bus.ADDER_A   = a_q;
    assign bus.ADDER_B   = b_q;
    assign bus.ADDER_CI  = ci_q;
    assign bus.ADDER_ADD = add_q;
    assign bus.ADDER_BCD = bcd_q;
    assign bus.ADDER_W16 = w16_q;

    assign bus.RESULT    = result_q;
    assign bus.C_OUT     = c_q;
    assign bus.V_OUT     = v_q;
    assign bus.N_OUT     = n_q;
    assign bus.Z_OUT     = z_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// tb_alu_operand_seq: directed + randomized bench for alu_operand_seq with a
// behavioural AddSubBCD adder wired to the adder port.
module tb_alu_operand_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_operand_seq_if bus ();

    alu_operand_seq dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // Behavioural adder: returns {V, C, S}. In byte mode S[15:8] is driven
    // with junk (~A[15:8]) so the sequencer must ignore it.
    function automatic logic [17:0] addsub(input logic [15:0] a, input logic [15:0] b,
                                           input logic ci, input logic add,
                                           input logic bcd, input logic w16);
        int w; int av; int bv; int sum; int c; int da; int db; int t;
        logic [15:0] bb; logic [15:0] s; logic co; logic vo;
        w   = w16 ? 16 : 8;
        bb  = add ? b : ~b;
        av  = w16 ? int'(a) : int'(a[7:0]);
        bv  = w16 ? int'(bb) : int'(bb[7:0]);
        sum = av + bv + (ci ? 1 : 0);
        s   = sum[15:0];
        co  = ((sum >> w) & 1) != 0;
        vo  = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
        if (bcd) begin
            c = ci ? 1 : 0;
            s = 16'h0000;
            for (int i = 0; i < w / 4; i++) begin
                da = int'((a >> (4 * i)) & 16'h000F);
                db = int'((b >> (4 * i)) & 16'h000F);
                if (add) begin
                    t = da + db + c;
                    if (t > 9) begin t = t - 10; c = 1; end else c = 0;
                end else begin
                    t = da - db - (1 - c);
                    if (t < 0) begin t = t + 10; c = 0; end else c = 1;
                end
                s[4 * i +: 4] = t[3:0];
            end
            co = (c != 0);
        end
        if (!w16) s[15:8] = ~a[15:8];
        return {vo, co, s};
    endfunction

    logic [17:0] add_res;
    always_comb add_res = addsub(bus.ADDER_A, bus.ADDER_B, bus.ADDER_CI,
                                 bus.ADDER_ADD, bus.ADDER_BCD, bus.ADDER_W16);
    assign bus.ADDER_S  = add_res[15:0];
    assign bus.ADDER_CO = add_res[16];
    assign bus.ADDER_VO = add_res[17];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {4'h0, bus.MEM_REQ, bus.MEM_HI, bus.ADDER_A, bus.ADDER_B, bus.ADDER_CI,
                bus.ADDER_ADD, bus.ADDER_BCD, bus.ADDER_W16, bus.RESULT, bus.C_OUT,
                bus.V_OUT, bus.N_OUT, bus.Z_OUT, bus.BUSY, bus.DONE};
    endfunction

    // One complete operation with a responding memory; checks against the model.
    task automatic run_op(input logic [15:0] acc, input logic ci, input logic add,
                          input logic bcd, input logic w16, input logic [7:0] lo,
                          input logic [7:0] hi, input int lo_wait, input int hi_wait,
                          input logic poke, output int lat);
        int lw; int hw; int k; int lo_cyc; int hi_cyc; logic seen;
        logic [15:0] exp_b; logic [17:0] r; logic [15:0] exp_res;
        lw = lo_wait; hw = hi_wait; lat = -1; lo_cyc = 0; hi_cyc = 0; seen = 1'b0;
        @(negedge clk);
        bus.ACC = acc; bus.CI = ci; bus.ADD = add; bus.BCD = bcd; bus.W16 = w16;
        bus.START = 1'b1; bus.MEM_ACK = 1'b0;
        @(posedge clk);
        k = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            bus.START = 1'b0; bus.ACC = acc; bus.CI = ci; bus.W16 = w16;
            bus.MEM_ACK = 1'b1; bus.MEM_DI = 8'($urandom);
            if (bus.DONE) begin
                seen = 1'b1; lat = k + 1;
                if (poke) begin bus.START = 1'b1; bus.ACC = ~acc; end
            end else if (bus.MEM_REQ && !bus.MEM_HI) begin
                lo_cyc++;
                if (lw > 0) begin
                    lw--; bus.MEM_ACK = 1'b0;
                    if (poke) begin bus.START = 1'b1; bus.ACC = ~acc; bus.W16 = ~w16; bus.CI = ~ci; end
                end else bus.MEM_DI = lo;
            end else if (bus.MEM_REQ && bus.MEM_HI) begin
                hi_cyc++;
                if (hw > 0) begin hw--; bus.MEM_ACK = 1'b0; end
                else bus.MEM_DI = hi;
            end
            if (!seen) begin @(posedge clk); k++; end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        exp_b   = w16 ? {hi, lo} : {8'h00, lo};
        r       = addsub(acc, exp_b, ci, add, bcd, w16);
        exp_res = w16 ? r[15:0] : {acc[15:8], r[7:0]};
        chk("latency", 64'(lat), 64'(3 + lo_wait + (w16 ? 1 + hi_wait : 0)));
        chk("lo_req_cycles", 64'(lo_cyc), 64'(1 + lo_wait));
        chk("hi_req_cycles", 64'(hi_cyc), 64'(w16 ? 1 + hi_wait : 0));
        chk("result", 64'(bus.RESULT), 64'(exp_res));
        chk("flags_cvnz", {60'd0, bus.C_OUT, bus.V_OUT, bus.N_OUT, bus.Z_OUT},
            {60'd0, r[16], r[17], (w16 ? r[15] : r[7]),
             (w16 ? (r[15:0] == 16'h0000) : (r[7:0] == 8'h00))});
        chk("adder_a", 64'(bus.ADDER_A), 64'(acc));
        chk("adder_b", 64'(bus.ADDER_B), 64'(exp_b));
        chk("adder_ctl", {60'd0, bus.ADDER_CI, bus.ADDER_ADD, bus.ADDER_BCD, bus.ADDER_W16},
            {60'd0, ci, add, bcd, w16});
        @(posedge clk);
        @(negedge clk);
        bus.START = 1'b0; bus.ACC = acc; bus.MEM_ACK = 1'b0;
        chk("idle_after_done", {62'd0, bus.BUSY, bus.DONE}, 64'd0);
    endtask

    initial begin
        int lat; int dones;
        rst_n = 1'b0;
        bus.START = 1'b0; bus.CANCEL = 1'b0; bus.ADD = 1'b0; bus.BCD = 1'b0;
        bus.W16 = 1'b0; bus.CI = 1'b0; bus.ACC = 16'h0000;
        bus.MEM_ACK = 1'b0; bus.MEM_DI = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;

        // 8-bit binary ADC
        run_op(16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F, 8'h00, 0, 0, 1'b0, lat);
        chk("t1_lat", 64'(lat), 64'd3);
        chk("t1_result", 64'(bus.RESULT), 64'h1243);
        chk("t1_cvnz", {60'd0, bus.C_OUT, bus.V_OUT, bus.N_OUT, bus.Z_OUT}, 64'h0);

        // 16-bit BCD ADC
        run_op(16'h9999, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h00, 0, 0, 1'b0, lat);
        chk("t2_lat", 64'(lat), 64'd4);
        chk("t2_result", 64'(bus.RESULT), 64'h0001);
        chk("t2_cz", {62'd0, bus.C_OUT, bus.Z_OUT}, 64'b10);

        // Wait states in FETCH_LO with START pokes while busy and in DONE
        run_op(16'h4321, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 8'h33, 3, 0, 1'b1, lat);
        chk("t4_lat", 64'(lat), 64'd7);
        chk("t4_result", 64'(bus.RESULT), 64'h7643);

        // 8-bit binary SBC
        run_op(16'hAB50, 1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 8'h00, 0, 0, 1'b0, lat);
        chk("t3_result", 64'(bus.RESULT), 64'hAB00);
        chk("t3_zcn", {61'd0, bus.Z_OUT, bus.C_OUT, bus.N_OUT}, 64'b110);

        // CANCEL together with MEM_ACK in FETCH_HI
        @(negedge clk);
        bus.ACC = 16'h0F0F; bus.CI = 1'b0; bus.ADD = 1'b1; bus.BCD = 1'b0; bus.W16 = 1'b1;
        bus.START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.START = 1'b0; bus.MEM_ACK = 1'b1; bus.MEM_DI = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        chk("cx_in_fetch_hi", {62'd0, bus.MEM_REQ, bus.MEM_HI}, 64'b11);
        bus.MEM_DI = 8'h77; bus.CANCEL = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.CANCEL = 1'b0; bus.MEM_ACK = 1'b0;
        chk("cx_idle", {62'd0, bus.BUSY, bus.DONE}, 64'd0);
        chk("cx_b_kept", 64'(bus.ADDER_B), 64'h005A);
        chk("cx_result_kept", 64'(bus.RESULT), 64'hAB00);
        chk("cx_flags_kept", {60'd0, bus.C_OUT, bus.V_OUT, bus.N_OUT, bus.Z_OUT}, 64'b1001);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.DONE || bus.BUSY) dones++;
        end
        chk("cx_no_done", 64'(dones), 64'd0);

        // CANCEL and START together in IDLE
        @(negedge clk);
        bus.ACC = 16'hFFFF; bus.START = 1'b1; bus.CANCEL = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.START = 1'b0; bus.CANCEL = 1'b0;
        chk("cs_no_start", {47'd0, bus.BUSY, bus.ADDER_A}, 64'h0F0F);

        // Reset asserted in EXEC
        @(negedge clk);
        bus.ACC = 16'h5555; bus.W16 = 1'b0; bus.START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.START = 1'b0; bus.MEM_ACK = 1'b1; bus.MEM_DI = 8'h11;
        @(posedge clk);
        @(negedge clk);
        bus.MEM_ACK = 1'b0;
        chk("rst_in_exec", {61'd0, bus.BUSY, bus.MEM_REQ, bus.DONE}, 64'b100);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0180, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 0, 0, 1'b0, lat);
        chk("post_rst_result", 64'(bus.RESULT), 64'h0100);

        // Randomized operations
        for (int i = 0; i < 25; i++) begin
            run_op(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
